key_event_scheduler: RTL and testbench

- Front-end controller for the four player buttons (a, b, c, d; active-low) that feed the 2-bit key-code path.
- Synchronises and debounces each button, and turns each debounced press into a single key event.
- Arbitrates simultaneous events with fixed priority and queues the 2-bit codes in a small FIFO.
- Game logic consumes the codes one at a time through a valid/ready handshake, so one physical press yields exactly one code.

---
 rtl/key_event_scheduler_if.sv | 9 +
 rtl/key_event_scheduler.sv | 114 +++++++++++
 tb/tb_key_event_scheduler.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_event_scheduler_if.sv
// Key-code handshake between the scheduler (master) and the game logic (slave).
interface key_event_scheduler_if;
  logic [1:0] key_code;
  logic       key_valid;
  logic       key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/key_event_scheduler.sv
// Button front end: sync, debounce, press-event detection, fixed-priority
// arbitration and a show-ahead key-code FIFO.
module key_event_scheduler #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [3:0]                          btn_n,
  input  logic                                clr_overflow,
  key_event_scheduler_if.master               key,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count,
  output logic                                overflow,
  output logic                                any_held
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned NW = $clog2(FIFO_DEPTH + 1);

  logic [3:0]    sync1, sync2;
  logic [3:0]    db_n, db_n_nxt;
  logic [CW-1:0] cnt     [4];
  logic [CW-1:0] cnt_nxt [4];
  logic [3:0]    press_q, press_nxt;
  logic [3:0]    pending, pending_nxt;
  logic [3:0]    grant;
  logic [1:0]    push_code;
  logic          pop, push, can_push, drop;
  logic [1:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  // Debounce: count consecutive mismatches, flip on the DEBOUNCE_CYCLES-th one.
  always_comb begin
    db_n_nxt  = db_n;
    press_nxt = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != db_n[i]) begin
        if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          db_n_nxt[i]  = ~db_n[i];
          press_nxt[i] = db_n[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  // Arbiter and pending update: lowest set bit wins when the FIFO can take it.
  always_comb begin
    pop       = (fifo_count != '0) && key.key_ready;
    can_push  = (fifo_count < NW'(FIFO_DEPTH)) || pop;
    grant     = can_push ? (pending & (~pending + 4'd1)) : 4'b0000;
    push      = (grant != 4'b0000);
    push_code = 2'b00;
    for (int unsigned i = 0; i < 4; i++) begin
      if (grant[i]) push_code = 2'(i);
    end
    // Clearing by the grant happens before the new event is merged, so a
    // bit granted and re-pressed at the same edge keeps the new event.
    drop        = |(press_q & pending & ~grant);
    pending_nxt = (pending & ~grant) | press_q;
  end

  // Synchroniser, debounce state, press pulse, pending and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '1;
      sync2    <= '1;
      db_n     <= '1;
      press_q  <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      any_held <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1    <= btn_n;
      sync2    <= sync1;
      db_n     <= db_n_nxt;
      press_q  <= press_nxt;
      pending  <= pending_nxt;
      any_held <= |(~db_n_nxt);
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= cnt_nxt[i];
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_code;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + NW'(1);
        2'b01:   fifo_count <= fifo_count - NW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign key.key_code  = mem[rd_ptr];
  assign key.key_valid = (fifo_count != '0);

endmodule

// File: tb/tb_key_event_scheduler.sv
// Self-checking bench for key_event_scheduler with a queue-based reference model.
module tb_key_event_scheduler;
  localparam int D  = 4;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_n = 4'hF;
  logic       clr_overflow = 1'b0;
  logic [2:0] fifo_count;
  logic       overflow, any_held;
  int         n_cmp = 0;
  int         n_err = 0;

  key_event_scheduler_if kif ();

  key_event_scheduler #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .clr_overflow(clr_overflow),
    .key(kif.master), .fifo_count(fifo_count), .overflow(overflow), .any_held(any_held)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF;
  bit         m_pressed [4];
  int         m_run [4];
  bit         m_pev [4];
  bit         m_pend [4];
  bit         m_ovf = 0, m_held = 0;
  int         q [$];

  task automatic model_edge();
    bit pop, drop, any_pend;
    int win;
    bit np [4];
    bit nev [4];
    if (reset) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_ovf = 0; m_held = 0; q.delete();
      for (int i = 0; i < 4; i++) begin
        m_pressed[i] = 0; m_run[i] = 0; m_pev[i] = 0; m_pend[i] = 0;
      end
    end else begin
      pop = (q.size() > 0) && kif.key_ready;
      any_pend = 0;
      for (int i = 0; i < 4; i++) any_pend |= m_pend[i];
      win = -1;
      if (any_pend && (q.size() < FD || pop))
        for (int i = 3; i >= 0; i--) if (m_pend[i]) win = i;
      drop = 0;
      for (int i = 0; i < 4; i++) begin
        np[i] = (i == win) ? 1'b0 : m_pend[i];
        if (m_pev[i]) begin
          if (np[i]) drop = 1;
          np[i] = 1;
        end
      end
      if (pop) void'(q.pop_front());
      if (win >= 0) q.push_back(win);
      if (drop) m_ovf = 1;
      else if (clr_overflow) m_ovf = 0;
      m_held = 0;
      for (int i = 0; i < 4; i++) begin
        bit raw;
        raw = !m_s2[i];
        nev[i] = 0;
        if (raw != m_pressed[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_pressed[i] = raw; m_run[i] = 0; nev[i] = raw;
          end
        end else m_run[i] = 0;
        m_held |= m_pressed[i];
      end
      for (int i = 0; i < 4; i++) begin m_pev[i] = nev[i]; m_pend[i] = np[i]; end
      m_s2 = m_s1;
      m_s1 = btn_n;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [5:0] dut_status();
    return {kif.key_valid, fifo_count, overflow, any_held};
  endfunction

  function automatic logic [5:0] exp_status();
    return {q.size() != 0, 3'(q.size()), m_ovf, m_held};
  endfunction

  task automatic test_reset();
    reset = 1; btn_n = 4'hF; kif.key_ready = 0; clr_overflow = 0;
    step(); step();
    n_cmp++;
    if ({dut_status(), kif.key_code} !== 8'h00) begin
      n_err++; $display("FAIL reset: got %b required %b", {dut_status(), kif.key_code}, 8'h00);
    end
    reset = 0;
    step();
  endtask

  task automatic test_single_press();
    btn_n = 4'b1110;
    for (int e = 1; e <= 8; e++) begin
      step();
      n_cmp++;
      if (kif.key_valid !== (e == 8)) begin
        n_err++; $display("FAIL press_latency: edge %0d valid %b required %b", e, kif.key_valid, e == 8);
      end
    end
    n_cmp++;
    if ({kif.key_code, fifo_count, any_held} !== {2'b00, 3'd1, 1'b1}) begin
      n_err++; $display("FAIL press_head: got %b required %b", {kif.key_code, fifo_count, any_held}, 6'b000011);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      n_cmp++;
      if (dut_status() !== exp_status() || fifo_count !== 3'd1) begin
        n_err++; $display("FAIL press_hold: status %b required %b", dut_status(), exp_status());
      end
    end
    btn_n = 4'hF; kif.key_ready = 1;
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++;
      if (dut_status() !== exp_status()) begin
        n_err++; $display("FAIL press_release: status %b required %b", dut_status(), exp_status());
      end
    end
    kif.key_ready = 0;
  endtask

  task automatic test_glitch();
    btn_n = 4'b1011;
    step(); step(); step();
    btn_n = 4'hF;
    for (int k = 0; k < 12; k++) begin
      step();
      n_cmp++;
      if (dut_status() !== exp_status() || fifo_count !== 3'd0 || any_held !== 1'b0) begin
        n_err++; $display("FAIL glitch: status %b required %b", dut_status(), exp_status());
      end
    end
  endtask

  task automatic test_simultaneous();
    btn_n = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      step();
      n_cmp++;
      if (dut_status() !== exp_status()) begin
        n_err++; $display("FAIL simul_fill: status %b required %b", dut_status(), exp_status());
      end
    end
    n_cmp++;
    if (fifo_count !== 3'd3) begin
      n_err++; $display("FAIL simul_count: got %0d required 3", fifo_count);
    end
    kif.key_ready = 1;
    for (int c = 1; c <= 3; c++) begin
      n_cmp++;
      if (kif.key_valid !== 1'b1 || kif.key_code !== 2'(c)) begin
        n_err++; $display("FAIL simul_order: code %b valid %b required %b", kif.key_code, kif.key_valid, 2'(c));
      end
      step();
    end
    kif.key_ready = 0; btn_n = 4'hF;
    for (int k = 0; k < 8; k++) step();
    n_cmp++;
    if (dut_status() !== exp_status() || kif.key_valid !== 1'b0) begin
      n_err++; $display("FAIL simul_drain: status %b required %b", dut_status(), exp_status());
    end
  endtask

  task automatic test_full_stall();
    btn_n = 4'b0000;
    for (int k = 0; k < 12; k++) step();
    btn_n = 4'hF;
    for (int k = 0; k < 8; k++) step();
    n_cmp++;
    if (fifo_count !== 3'd4 || dut_status() !== exp_status()) begin
      n_err++; $display("FAIL stall_full: count %0d required 4", fifo_count);
    end
    btn_n = 4'b1110;
    for (int k = 0; k < 12; k++) begin
      step();
      n_cmp++;
      if (dut_status() !== exp_status() || fifo_count !== 3'd4) begin
        n_err++; $display("FAIL stall_wait: status %b required %b", dut_status(), exp_status());
      end
    end
    btn_n = 4'hF;
    kif.key_ready = 1;
    step();
    kif.key_ready = 0;
    n_cmp++;
    if (fifo_count !== 3'd4 || kif.key_code !== 2'b01) begin
      n_err++; $display("FAIL stall_poppush: count %0d head %b required 4 01", fifo_count, kif.key_code);
    end
    for (int k = 0; k < 8; k++) step();
    n_cmp++;
    if (q.size() != 4 || q[3] != 0 || dut_status() !== exp_status()) begin
      n_err++; $display("FAIL stall_tail: status %b required %b", dut_status(), exp_status());
    end
  endtask

  task automatic test_overflow();
    btn_n = 4'b1101;
    for (int k = 0; k < 10; k++) step();
    btn_n = 4'hF;
    for (int k = 0; k < 8; k++) step();
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL ovf_early: got %b required 0", overflow);
    end
    btn_n = 4'b1101;
    for (int k = 0; k < 10; k++) step();
    n_cmp++;
    if (overflow !== 1'b1 || fifo_count !== 3'd4 || dut_status() !== exp_status()) begin
      n_err++; $display("FAIL ovf_set: got %b required 1", overflow);
    end
    clr_overflow = 1;
    step();
    clr_overflow = 0;
    n_cmp++;
    if (overflow !== 1'b0 || dut_status() !== exp_status()) begin
      n_err++; $display("FAIL ovf_clear: got %b required 0", overflow);
    end
    btn_n = 4'hF;
    for (int k = 0; k < 8; k++) step();
  endtask

  task automatic test_reset_mid();
    reset = 1; step(); reset = 0;
    btn_n = 4'b0000;
    for (int k = 0; k < 10; k++) step();
    n_cmp++;
    if (fifo_count !== 3'd3 || kif.key_valid !== 1'b1) begin
      n_err++; $display("FAIL rstmid_pre: count %0d required 3", fifo_count);
    end
    reset = 1; btn_n = 4'hF;
    step();
    reset = 0;
    n_cmp++;
    if (dut_status() !== 6'b000000) begin
      n_err++; $display("FAIL rstmid_post: status %b required 000000", dut_status());
    end
    for (int k = 0; k < 15; k++) begin
      step();
      n_cmp++;
      if (dut_status() !== 6'b000000 || dut_status() !== exp_status()) begin
        n_err++; $display("FAIL rstmid_idle: status %b required 000000", dut_status());
      end
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int k = 0; k < 1500; k++) begin
      if (hold == 0) begin
        btn_n = 4'($urandom);
        hold = $urandom_range(1, 9);
      end
      hold--;
      kif.key_ready = ($urandom_range(0, 3) == 0);
      clr_overflow = ($urandom_range(0, 15) == 0);
      step();
      n_cmp++;
      if (dut_status() !== exp_status()) begin
        n_err++; $display("FAIL random_status: cycle %0d status %b required %b", k, dut_status(), exp_status());
      end
      if (q.size() > 0) begin
        n_cmp++;
        if (kif.key_code !== 2'(q[0])) begin
          n_err++; $display("FAIL random_code: cycle %0d code %b required %b", k, kif.key_code, 2'(q[0]));
        end
      end
    end
    btn_n = 4'hF; clr_overflow = 0; kif.key_ready = 0;
  endtask

  initial begin
    kif.key_ready = 0;
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_full_stall();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
